// File: rtl/scene_pkg.sv
// -----------------------------------------------------------------------------
// scene_pkg
//   Shared definitions for the scene sequencers.
//   - scene_state_t      : 3-bit state encoding (IDLE=0 .. DONE=4), shared with
//                          the other scene sequencers.
//   - DEFAULT_FRAME_LINE : VGA line on which the once-per-frame tick fires.
//   - counter_width()    : width helper for the frame/glyph counters.
// -----------------------------------------------------------------------------
package scene_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REVEAL = 3'd1,
    ST_HOLD   = 3'd2,
    ST_BLINK  = 3'd3,
    ST_DONE   = 3'd4
  } scene_state_t;

  localparam int DEFAULT_FRAME_LINE = 480;

  // $clog2 of the largest terminal value plus one, so a counter compared
  // against its terminal value can never wrap.
  function automatic int counter_width(input int a, input int b, input int c,
                                       input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// -----------------------------------------------------------------------------
// scene_sequencer_if
//   Request/status bundle between the top-level game FSM (master) and a scene
//   sequencer (slave).
//   start      : master -> slave, single-cycle (re)start request
//   skip       : master -> slave, single-cycle jump-to-final-frame request
//   glyph_mask : slave -> master/scene mux, bit i high = glyph i drawn
//   busy       : slave -> master, animation in progress
//   done       : slave -> master, level, final frame reached
// -----------------------------------------------------------------------------
interface scene_sequencer_if #(
  parameter int NUM_GLYPHS = 4
);

  logic                  start;
  logic                  skip;
  logic [NUM_GLYPHS-1:0] glyph_mask;
  logic                  busy;
  logic                  done;

  modport master (output start, output skip,
                  input  glyph_mask, input busy, input done);

  modport slave  (input  start, input skip,
                  output glyph_mask, output busy, output done);

endinterface

// File: rtl/frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
//   One-cycle tick per video frame, taken from the shared VGA counters.
//   Fires on the first clk cycle in which (vga_v == FRAME_LINE, vga_h == 0),
//   so it stays single regardless of the clk / pixel-clock ratio.
//   Ports: clk, rst (sync, active-high), vga_h, vga_v (10 bit) -> tick.
// -----------------------------------------------------------------------------
module frame_tick_gen
  import scene_pkg::*;
#(
  parameter int FRAME_LINE = DEFAULT_FRAME_LINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vga_h,
  input  logic [9:0] vga_v,
  output logic       tick
);

  logic match;
  logic match_q;

  assign match = (vga_v == 10'(FRAME_LINE)) && (vga_h == 10'd0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create simulation races.
  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match;
  end

  assign tick = match & ~match_q;

endmodule

// File: rtl/scene_sequencer.sv
// -----------------------------------------------------------------------------
// scene_sequencer
//   Animates the lettering of the end-of-game scene: reveals glyphs one per
//   REVEAL_FRAMES frames, holds the full word, blinks it, then reports done.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     vga_h, vga_v  : shared VGA counters (frame tick source)
//     ctrl (slave)  : start/skip requests in; glyph_mask/busy/done out
//   All outputs are registered.
//   Build option: define SCENE_SEQ_BLINK_EN to include the BLINK phase; when
//   undefined, the end of HOLD goes straight to DONE.
// -----------------------------------------------------------------------------
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int NUM_GLYPHS    = 4,
  parameter int REVEAL_FRAMES = 15,
  parameter int HOLD_FRAMES   = 60,
  parameter int BLINK_FRAMES  = 30,
  parameter int BLINK_COUNT   = 3,
  parameter int FRAME_LINE    = DEFAULT_FRAME_LINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vga_h,
  input  logic [9:0] vga_v,
  scene_sequencer_if.slave ctrl
);

  localparam int CNT_W = counter_width(REVEAL_FRAMES, HOLD_FRAMES, BLINK_FRAMES,
                                       2 * BLINK_COUNT, NUM_GLYPHS);

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [NUM_GLYPHS-1:0] mask_t;

  localparam cnt_t REVEAL_LAST = cnt_t'(REVEAL_FRAMES - 1);
  localparam cnt_t HOLD_LAST   = cnt_t'(HOLD_FRAMES - 1);
  localparam cnt_t GLYPH_LAST  = cnt_t'(NUM_GLYPHS - 1);
`ifdef SCENE_SEQ_BLINK_EN
  localparam cnt_t BLINK_LAST  = cnt_t'(BLINK_FRAMES - 1);
  // Entering BLINK is already the first (off) toggle, so inside BLINK the
  // last toggle is number 2*BLINK_COUNT-2 counted from zero.
  localparam cnt_t TOGGLE_LAST = cnt_t'(2 * BLINK_COUNT - 2);
`endif

  scene_state_t state_q, state_d;
  cnt_t         fcnt_q, fcnt_d;
  cnt_t         gcnt_q, gcnt_d;
  mask_t        mask_q, mask_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tick;

  frame_tick_gen #(
    .FRAME_LINE (FRAME_LINE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .vga_h (vga_h),
    .vga_v (vga_v),
    .tick  (tick)
  );

  // State register together with the registered datapath/outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      gcnt_q  <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      gcnt_q  <= gcnt_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. skip beats start everywhere except DONE, where skip is
  // ignored and start replays.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl.skip)       state_d = ST_DONE;
        else if (ctrl.start) state_d = ST_REVEAL;
      end
      ST_REVEAL: begin
        if (ctrl.skip) state_d = ST_DONE;
        else if (tick && fcnt_q == REVEAL_LAST && gcnt_q == GLYPH_LAST)
          state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (ctrl.skip) state_d = ST_DONE;
        else if (tick && fcnt_q == HOLD_LAST)
`ifdef SCENE_SEQ_BLINK_EN
          state_d = ST_BLINK;
`else
          state_d = ST_DONE;
`endif
      end
`ifdef SCENE_SEQ_BLINK_EN
      ST_BLINK: begin
        if (ctrl.skip) state_d = ST_DONE;
        else if (tick && fcnt_q == BLINK_LAST && gcnt_q == TOGGLE_LAST)
          state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (ctrl.start) state_d = ST_REVEAL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output logic: counters are cleared and the mask is set to its
  // entry value on every state change; otherwise ticks advance the counters.
  always_comb begin
    fcnt_d = fcnt_q;
    gcnt_d = gcnt_q;
    mask_d = mask_q;

    if (state_d != state_q) begin
      fcnt_d = '0;
      gcnt_d = '0;
      unique case (state_d)
        ST_HOLD, ST_DONE: mask_d = '1;
        default:          mask_d = '0;  // IDLE, REVEAL, and BLINK's first off half
      endcase
    end else if (tick) begin
      unique case (state_q)
        ST_REVEAL: begin
          if (fcnt_q == REVEAL_LAST) begin
            mask_d = mask_t'({mask_q, 1'b1});
            fcnt_d = '0;
            gcnt_d = gcnt_q + 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        ST_HOLD: fcnt_d = fcnt_q + 1'b1;  // terminal tick always changes state
`ifdef SCENE_SEQ_BLINK_EN
        ST_BLINK: begin
          if (fcnt_q == BLINK_LAST) begin
            mask_d = ~mask_q;
            fcnt_d = '0;
            gcnt_d = gcnt_q + 1'b1;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
`endif
        default: ;  // ticks are ignored in IDLE and DONE
      endcase
    end

    busy_d = (state_d == ST_REVEAL) || (state_d == ST_HOLD)
          || (state_d == ST_BLINK);
    done_d = (state_d == ST_DONE);
  end

  assign ctrl.glyph_mask = mask_q;
  assign ctrl.busy       = busy_q;
  assign ctrl.done       = done_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scene_sequencer
//   Self-checking bench for scene_sequencer with NUM_GLYPHS=4, REVEAL_FRAMES=2,
//   HOLD_FRAMES=3, BLINK_FRAMES=1, BLINK_COUNT=2. Works with or without
//   SCENE_SEQ_BLINK_EN. A tick-count model predicts the outputs every cycle;
//   directed literal checks pin the model at the interesting ticks.
//   Frames are abridged: only a few (h,v) positions around the tick line are
//   visited, each held for 4 clks, so one frame is 28 clks.
// -----------------------------------------------------------------------------
module tb_scene_sequencer;

  localparam int N  = 4;
  localparam int R  = 2;
  localparam int H  = 3;
  localparam int B  = 1;
  localparam int BC = 2;
  localparam int FL = 480;

  // Ticks from start to DONE. The blink's first off half begins on the
  // hold's terminal tick, so the word is lit for exactly H frames.
`ifdef SCENE_SEQ_BLINK_EN
  localparam int TOTAL = N * R + H + (2 * BC - 1) * B;   // 14
`else
  localparam int TOTAL = N * R + H;                      // 11
`endif

  localparam int NPOS = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] vga_h;
  logic [9:0] vga_v;

  int checks = 0;
  int errors = 0;

  scene_sequencer_if #(.NUM_GLYPHS(N)) ctrl_if ();

  scene_sequencer #(
    .NUM_GLYPHS    (N),
    .REVEAL_FRAMES (R),
    .HOLD_FRAMES   (H),
    .BLINK_FRAMES  (B),
    .BLINK_COUNT   (BC),
    .FRAME_LINE    (FL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .vga_h (vga_h),
    .vga_v (vga_v),
    .ctrl  (ctrl_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int   m_phase = M_IDLE;
  int   m_n = 0;          // ticks counted since start
  int   tick_cnt = 0;     // all ticks seen outside reset (stimulus pacing)
  logic m_prev = 1'b0;
  bit   compare_en = 1'b0;

  function automatic logic [N-1:0] model_mask(input int ph, input int n);
    int k;
    if (ph == M_IDLE) return '0;
    if (ph == M_DONE) return '1;
    if (n < N * R) return N'((1 << (n / R)) - 1);
    if (n < N * R + H) return '1;
    k = (n - (N * R + H)) / B + 1;           // toggles so far
    return (k % 2 == 1) ? '0 : '1;
  endfunction

  always @(posedge clk) begin
    logic m, t;
    m = (vga_v == 10'(FL)) && (vga_h == 10'd0);
    t = m && !m_prev;
    m_prev = rst ? 1'b0 : m;
    if (rst) begin
      m_phase = M_IDLE;
      m_n = 0;
    end else begin
      if (t) tick_cnt++;
      case (m_phase)
        M_IDLE: begin
          if (ctrl_if.skip)       m_phase = M_DONE;
          else if (ctrl_if.start) begin m_phase = M_RUN; m_n = 0; end
        end
        M_RUN: begin
          if (ctrl_if.skip) m_phase = M_DONE;
          else if (t) begin
            m_n++;
            if (m_n == TOTAL) m_phase = M_DONE;
          end
        end
        default: begin
          if (ctrl_if.start) begin m_phase = M_RUN; m_n = 0; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      check("model mask", 32'(ctrl_if.glyph_mask), 32'(model_mask(m_phase, m_n)));
      check("model busy", 32'(ctrl_if.busy), 32'(m_phase == M_RUN));
      check("model done", 32'(ctrl_if.done), 32'(m_phase == M_DONE));
    end
  end

  // ------------------------------------------------------------- stimulus
  logic [9:0] pos_h [NPOS] = '{10'd0, 10'd100, 10'd0, 10'd0, 10'd1, 10'd0, 10'd0};
  logic [9:0] pos_v [NPOS] = '{10'd0, 10'd479, 10'd479, 10'd480, 10'd480, 10'd481, 10'd524};
  int pos = 0;
  int sub = 0;

  task automatic advance_clk();
    vga_h = pos_h[pos];
    vga_v = pos_v[pos];
    @(posedge clk);
    #1;
    sub++;
    if (sub == 4) begin
      sub = 0;
      pos = (pos + 1) % NPOS;
    end
  endtask

  task automatic hold_pos(input int h, input int v, input int n);
    vga_h = 10'(h);
    vga_v = 10'(v);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ticks(input int k);
    int target;
    int budget;
    target = tick_cnt + k;
    budget = 40 * k;
    while (tick_cnt < target && budget > 0) begin
      advance_clk();
      budget--;
    end
    if (tick_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_ticks timeout: got %0d ticks, expected %0d", tick_cnt, target);
    end
  endtask

  task automatic pulse(input bit do_start, input bit do_skip);
    ctrl_if.start = do_start;
    ctrl_if.skip  = do_skip;
    advance_clk();
    ctrl_if.start = 1'b0;
    ctrl_if.skip  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ctrl_if.start = 1'b0;
    ctrl_if.skip  = 1'b0;
    vga_h = 10'd0;
    vga_v = 10'd480;

    // 1. reset with match held high through release
    hold_pos(0, 480, 3);
    compare_en = 1'b1;
    check("reset mask", 32'(ctrl_if.glyph_mask), 32'h0);
    check("reset busy", 32'(ctrl_if.busy), 32'h0);
    check("reset done", 32'(ctrl_if.done), 32'h0);
    rst = 1'b0;
    hold_pos(0, 480, 4);
    check("post-reset mask", 32'(ctrl_if.glyph_mask), 32'h0);
    pos = 4;
    sub = 0;

    // 2. full run
    pulse(1'b1, 1'b0);
    check("run busy rise", 32'(ctrl_if.busy), 32'h1);
    wait_ticks(1);
    check("tick1 mask", 32'(ctrl_if.glyph_mask), 32'h0);
    wait_ticks(1);
    check("tick2 mask", 32'(ctrl_if.glyph_mask), 32'h1);
    wait_ticks(2);
    check("tick4 mask", 32'(ctrl_if.glyph_mask), 32'h3);
    wait_ticks(2);
    check("tick6 mask", 32'(ctrl_if.glyph_mask), 32'h7);
    wait_ticks(2);
    check("tick8 mask", 32'(ctrl_if.glyph_mask), 32'hF);
    wait_ticks(2);
    check("tick10 mask", 32'(ctrl_if.glyph_mask), 32'hF);
    check("tick10 done", 32'(ctrl_if.done), 32'h0);
    wait_ticks(1);
`ifdef SCENE_SEQ_BLINK_EN
    check("tick11 mask", 32'(ctrl_if.glyph_mask), 32'h0);
    wait_ticks(1);
    check("tick12 mask", 32'(ctrl_if.glyph_mask), 32'hF);
    wait_ticks(1);
    check("tick13 mask", 32'(ctrl_if.glyph_mask), 32'h0);
    check("tick13 busy", 32'(ctrl_if.busy), 32'h1);
    wait_ticks(1);
    check("tick14 mask", 32'(ctrl_if.glyph_mask), 32'hF);
`else
    check("tick11 mask", 32'(ctrl_if.glyph_mask), 32'hF);
`endif
    check("end done", 32'(ctrl_if.done), 32'h1);
    check("end busy", 32'(ctrl_if.busy), 32'h0);
    wait_ticks(2);
    check("done holds mask", 32'(ctrl_if.glyph_mask), 32'hF);

    // 3. skip during REVEAL
    pulse(1'b1, 1'b0);
    wait_ticks(3);
    check("pre-skip mask", 32'(ctrl_if.glyph_mask), 32'h1);
    pulse(1'b0, 1'b1);
    check("skip mask", 32'(ctrl_if.glyph_mask), 32'hF);
    check("skip done", 32'(ctrl_if.done), 32'h1);
    check("skip busy", 32'(ctrl_if.busy), 32'h0);
    wait_ticks(2);
    check("post-skip mask", 32'(ctrl_if.glyph_mask), 32'hF);

    // 4a. start ignored in HOLD
    pulse(1'b1, 1'b0);
    wait_ticks(9);
    check("hold mask", 32'(ctrl_if.glyph_mask), 32'hF);
    pulse(1'b1, 1'b0);
    check("hold start busy", 32'(ctrl_if.busy), 32'h1);
    wait_ticks(TOTAL - 10);
    check("one tick early done", 32'(ctrl_if.done), 32'h0);
    wait_ticks(1);
    check("hold-start done", 32'(ctrl_if.done), 32'h1);

    // 4c. start+skip in DONE -> replay
    pulse(1'b1, 1'b1);
    check("done start+skip mask", 32'(ctrl_if.glyph_mask), 32'h0);
    check("done start+skip busy", 32'(ctrl_if.busy), 32'h1);
    check("done start+skip done", 32'(ctrl_if.done), 32'h0);

    // 6a. reset mid-animation
`ifdef SCENE_SEQ_BLINK_EN
    wait_ticks(11);
    check("blink-off mask", 32'(ctrl_if.glyph_mask), 32'h0);
`else
    wait_ticks(9);
    check("hold mask 2", 32'(ctrl_if.glyph_mask), 32'hF);
`endif
    rst = 1'b1;
    advance_clk();
    rst = 1'b0;
    check("midrun reset mask", 32'(ctrl_if.glyph_mask), 32'h0);
    check("midrun reset done", 32'(ctrl_if.done), 32'h0);
    check("midrun reset busy", 32'(ctrl_if.busy), 32'h0);

    // 4b. start+skip in IDLE -> DONE
    pulse(1'b1, 1'b1);
    check("idle start+skip done", 32'(ctrl_if.done), 32'h1);
    check("idle start+skip mask", 32'(ctrl_if.glyph_mask), 32'hF);
    check("idle start+skip busy", 32'(ctrl_if.busy), 32'h0);

    // 5. tick uniqueness: match held for 16 clks counts once
    pulse(1'b1, 1'b0);
    hold_pos(0, 0, 2);
    hold_pos(0, 480, 16);
    hold_pos(0, 481, 4);
    check("long match mask", 32'(ctrl_if.glyph_mask), 32'h0);
    check("long match busy", 32'(ctrl_if.busy), 32'h1);
    wait_ticks(1);
    check("after long match mask", 32'(ctrl_if.glyph_mask), 32'h1);

    repeat (3) advance_clk();
    compare_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
